qspi_flash_responder: RTL and testbench
=======================================

// Module: qspi_flash_responder
// PURPOSE
//  Flash-side end of the quad-SPI memory bus: emulates a serial NOR flash answering the board's QSPI master
//  (SCK/CS/IO0..IO3) from an on-chip memory preloaded over a parallel port. Used on the bench and on a
//  loop-back build to exercise the flash reader without a physical device. Pin tristating is at the top level.
// PARAMETERS
//  MEM_AW        10          on-chip memory address width (bytes = 2**MEM_AW); wire address is always 24 bits
//  DUMMY_CYC     8           dummy SCK cycles for opcode 0x6B
//  JEDEC_ID      24'hEF4018  bytes returned by 0x9F, MSB byte first
//  STATUS_VAL    8'h00       byte returned repeatedly by 0x05
// PORTS
//  mclk          in   1   system clock; SCK must be <= mclk/8
//  RESETn        in   1   asynchronous active-low reset
//  sck           in   1   bus serial clock from master (mode 0)
//  cs_n          in   1   bus chip select, active low
//  io_in         in   4   bus IO0..IO3 as sampled from pads
//  io_out        out  4   values to drive on IO0..IO3
//  io_oe         out  4   per-pin output enable (1 = drive)
//  mem_we        in   1   preload write strobe (mclk domain)
//  mem_addr      in   MEM_AW  preload address
//  mem_wdata     in   8   preload data
//  busy          out  1   high while a transaction is selected
//  cmd_err       out  1   one-mclk pulse on unsupported opcode
// BEHAVIOUR
//  Reset: io_out=0, io_oe=0, busy=0, cmd_err=0, FSM=IDLE, address/bit counters 0; memory contents undefined.
//  sck, cs_n, io_in pass 2-flop synchronizers; rise/fall pulses from 3rd stage. All timing below is post-sync.
//  Inputs sampled on sck rise; outputs updated on sck fall (one mclk after fall pulse). Latency from pad
//   edge to action: 3 mclk, hence the mclk/8 SCK limit.
//  States: IDLE -> CMD (cs_n falls) -> by opcode after 8th rise:
//   0x03 READ      -> ADDR (24 bits on IO0, MSB first) -> DATA1
//   0x6B QUAD READ -> ADDR (24 bits on IO0) -> DUMMY (DUMMY_CYC rises) -> DATA4
//   0x9F RDID      -> ID;   0x05 RDSR -> STAT;   other -> IGNORE, cmd_err pulse
//  DATA1: byte MSB first on IO1 only; io_oe=4'b0010. DATA4: high nibble then low, IO3=bit3;
//   io_oe=4'b1111. First output bit/nibble driven on the fall following the last ADDR/DUMMY rise.
//  Byte fetch: memory read at byte boundary; addr = wire_addr[MEM_AW-1:0]; increments per byte,
//   wraps 2**MEM_AW-1 -> 0 (upper wire-address bits ignored).
//  ID: 3 JEDEC bytes on IO1 then 0x00 forever. STAT: STATUS_VAL repeated on IO1.
//  IGNORE and CMD/ADDR/DUMMY: io_oe=0.
//  cs_n rise (any state, any bit count): io_oe=0 within 1 mclk of the sync pulse, FSM->IDLE, partial
//   byte/address discarded, busy=0. cs_n low at reset release is ignored until a high->low edge is seen.
//  sck edges while cs_n high are ignored. Simultaneous cs_n rise and sck edge: cs_n wins.
//  mem_we takes effect next mclk; a preload to the byte being fetched in the same mclk returns old data.
//  busy = cs_n synchronized low and FSM != IDLE.
// STRUCTURE
//  Package qspi_flash_pkg: opcode constants (OP_READ, OP_QREAD, OP_RDID, OP_RDSR), FSM state enum.
//  Sub-module qspi_pin_sync: 2-flop sync of sck/cs_n/io_in + rise/fall pulse generation.
//  Memory: single inferred block RAM, write port = preload, read port = FSM fetch.
// TESTING
//  Preload 0x000..0x003 = 11,22,33,44; 0x03 addr 0x000000, 32 SCK -> IO1 bytes 11,22,33,44; io_oe=0010.
//  0x6B addr 0x000002, 8 dummy, 4 SCK -> IO3..0 nibbles 3,3,4,4; io_oe=1111 only during data.
//  0x03 addr 0x0003FF (MEM_AW=10), 16 SCK -> mem[0x3FF] then mem[0x000] (wrap).
//  0x9F, 32 SCK -> EF,40,18,00. 0x05, 16 SCK -> 00,00.
//  Opcode 0xAB -> one cmd_err pulse, io_oe=0 until cs_n high; cs_n raised mid-address of 0x03 -> io_oe=0,
//   busy=0, next 0x03 transaction returns correct data.
//  RESETn asserted mid-DATA4 -> io_oe=0 immediately; after release, cs_n still low gives no drive.

Source files
------------

// File: rtl/qspi_flash_pkg.sv
// Shared definitions for the QSPI flash responder.
//   - Supported opcodes (single-bit read, quad-output read, JEDEC ID, status)
//   - Transaction state encoding used by the responder FSM
package qspi_flash_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_QREAD = 8'h6B;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA1,
        ST_DATA4,
        ST_ID,
        ST_STAT,
        ST_IGNORE
    } qspi_state_t;

endpackage

// File: rtl/qspi_pin_sync.sv
// Brings the asynchronous QSPI pad signals into the mclk domain.
// Ports:
//   i_clk, i_rst_n      system clock, asynchronous active-low reset
//   i_sck, i_cs_n, i_io raw pad inputs
//   o_sck_rise/fall     one-mclk pulses on synchronized SCK edges
//   o_cs_n              synchronized chip select level
//   o_cs_rise/fall      one-mclk pulses on synchronized CS edges
//   o_io                synchronized IO0..IO3, aligned with the SCK pulses
module qspi_pin_sync (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sck,
    input  logic       i_cs_n,
    input  logic [3:0] i_io,
    output logic       o_sck_rise,
    output logic       o_sck_fall,
    output logic       o_cs_n,
    output logic       o_cs_rise,
    output logic       o_cs_fall,
    output logic [3:0] o_io
);

    // [0] and [1] form the synchronizer, [2] is the edge-detect history stage.
    logic [2:0] r_sck_sync;
    logic [2:0] r_cs_sync;
    logic [3:0] r_io_s1;
    logic [3:0] r_io_s2;

    // The CS chain resets low: a select already asserted when reset is
    // released then produces no falling edge, so it is ignored until the
    // master deasserts and reasserts it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_sync <= '0;
            r_cs_sync  <= '0;
            r_io_s1    <= '0;
            r_io_s2    <= '0;
        end else begin
            r_sck_sync <= {r_sck_sync[1:0], i_sck};
            r_cs_sync  <= {r_cs_sync[1:0], i_cs_n};
            r_io_s1    <= i_io;
            r_io_s2    <= r_io_s1;
        end
    end

    assign o_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];
    assign o_sck_fall = ~r_sck_sync[1] & r_sck_sync[2];
    assign o_cs_n     = r_cs_sync[1];
    assign o_cs_rise  = r_cs_sync[1] & ~r_cs_sync[2];
    assign o_cs_fall  = ~r_cs_sync[1] & r_cs_sync[2];
    assign o_io       = r_io_s2;

endmodule

// File: rtl/qspi_flash_responder.sv
// Serial NOR flash emulator answering a mode-0 QSPI master from on-chip RAM.
// Ports:
//   mclk, RESETn              system clock, asynchronous active-low reset
//   sck, cs_n, io_in          bus pins from the pads (asynchronous to mclk)
//   io_out, io_oe             pin drive values and per-pin output enables
//   mem_we, mem_addr, mem_wdata  parallel preload port (mclk domain)
//   busy                      a transaction is selected and in progress
//   cmd_err                   one-mclk pulse on an unsupported opcode
// Commands: 0x03 read, 0x6B quad-output read, 0x9F JEDEC ID, 0x05 status.
module qspi_flash_responder
    import qspi_flash_pkg::*;
#(
    parameter int          MEM_AW     = 10,
    parameter int          DUMMY_CYC  = 8,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic              mclk,
    input  logic              RESETn,
    input  logic              sck,
    input  logic              cs_n,
    input  logic [3:0]        io_in,
    output logic [3:0]        io_out,
    output logic [3:0]        io_oe,
    input  logic              mem_we,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [7:0] LP_DUMMY_LAST = 8'(DUMMY_CYC - 1);

    logic       w_sck_rise;
    logic       w_sck_fall;
    logic       w_cs_n;
    logic       w_cs_rise;
    logic       w_cs_fall;
    logic [3:0] w_io;
    logic       w_unused_io;

    qspi_pin_sync u_sync (
        .i_clk      (mclk),
        .i_rst_n    (RESETn),
        .i_sck      (sck),
        .i_cs_n     (cs_n),
        .i_io       (io_in),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_cs_n     (w_cs_n),
        .o_cs_rise  (w_cs_rise),
        .o_cs_fall  (w_cs_fall),
        .o_io       (w_io)
    );

    // Only IO0 carries master-to-flash traffic for the supported commands.
    assign w_unused_io = ^w_io[3:1];

    qspi_state_t       r_state;
    logic [7:0]        r_bitcnt;
    logic [7:0]        r_cmd;
    logic [MEM_AW-1:0] r_faddr;
    logic [7:0]        r_rdata;
    logic [7:0]        r_obyte;
    logic [2:0]        r_ocnt;
    logic [1:0]        r_idx;
    logic [3:0]        r_io_out;
    logic [3:0]        r_io_oe;
    logic              r_cmd_err;
    logic [7:0]        w_cmd_next;
    logic [7:0]        w_src;

    logic [7:0] r_mem [0:(2**MEM_AW)-1];

    // Read-first RAM: a preload to the address being fetched in the same
    // cycle returns the previous contents.
    always_ff @(posedge mclk) begin
        if (mem_we) begin
            r_mem[mem_addr] <= mem_wdata;
        end
        r_rdata <= r_mem[r_faddr];
    end

    assign w_cmd_next = {r_cmd[6:0], w_io[0]};

    // Byte to start shifting out at the next byte boundary.
    always_comb begin
        w_src = r_rdata;
        case (r_state)
            ST_ID: begin
                case (r_idx)
                    2'd0:    w_src = JEDEC_ID[23:16];
                    2'd1:    w_src = JEDEC_ID[15:8];
                    2'd2:    w_src = JEDEC_ID[7:0];
                    default: w_src = 8'h00;
                endcase
            end
            ST_STAT: w_src = STATUS_VAL;
            default: w_src = r_rdata;
        endcase
    end

    // CS edges take priority over SCK edges in the same cycle. The address
    // is shifted straight into the MEM_AW-bit fetch pointer, so the upper
    // wire-address bits fall off the top and are ignored.
    always_ff @(posedge mclk or negedge RESETn) begin
        if (!RESETn) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= '0;
            r_cmd     <= '0;
            r_faddr   <= '0;
            r_obyte   <= '0;
            r_ocnt    <= '0;
            r_idx     <= '0;
            r_io_out  <= '0;
            r_io_oe   <= '0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            if (w_cs_rise) begin
                r_state  <= ST_IDLE;
                r_bitcnt <= '0;
                r_ocnt   <= '0;
                r_io_out <= '0;
                r_io_oe  <= '0;
            end else if (w_cs_fall) begin
                r_state  <= ST_CMD;
                r_bitcnt <= '0;
                r_cmd    <= '0;
                r_faddr  <= '0;
                r_ocnt   <= '0;
                r_idx    <= '0;
                r_io_out <= '0;
                r_io_oe  <= '0;
            end else if (!w_cs_n && w_sck_rise) begin
                case (r_state)
                    ST_CMD: begin
                        r_cmd    <= w_cmd_next;
                        r_bitcnt <= r_bitcnt + 8'd1;
                        if (r_bitcnt == 8'd7) begin
                            r_bitcnt <= '0;
                            case (w_cmd_next)
                                OP_READ, OP_QREAD: r_state <= ST_ADDR;
                                OP_RDID:           r_state <= ST_ID;
                                OP_RDSR:           r_state <= ST_STAT;
                                default: begin
                                    r_state   <= ST_IGNORE;
                                    r_cmd_err <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ST_ADDR: begin
                        r_faddr  <= {r_faddr[MEM_AW-2:0], w_io[0]};
                        r_bitcnt <= r_bitcnt + 8'd1;
                        if (r_bitcnt == 8'd23) begin
                            r_bitcnt <= '0;
                            if (r_cmd == OP_QREAD) begin
                                r_state <= (DUMMY_CYC == 0) ? ST_DATA4 : ST_DUMMY;
                            end else begin
                                r_state <= ST_DATA1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        r_bitcnt <= r_bitcnt + 8'd1;
                        if (r_bitcnt == LP_DUMMY_LAST) begin
                            r_bitcnt <= '0;
                            r_state  <= ST_DATA4;
                        end
                    end
                    default: ;
                endcase
            end else if (!w_cs_n && w_sck_fall) begin
                case (r_state)
                    ST_DATA1, ST_ID, ST_STAT: begin
                        r_io_oe <= 4'b0010;
                        r_ocnt  <= r_ocnt + 3'd1;
                        if (r_ocnt == 3'd0) begin
                            r_io_out <= {2'b00, w_src[7], 1'b0};
                            r_obyte  <= {w_src[6:0], 1'b0};
                            if (r_state == ST_DATA1) begin
                                r_faddr <= r_faddr + MEM_AW'(1);
                            end
                            // ID index saturates at 3, which selects 0x00 forever.
                            if (r_state == ST_ID && r_idx != 2'd3) begin
                                r_idx <= r_idx + 2'd1;
                            end
                        end else begin
                            r_io_out <= {2'b00, r_obyte[7], 1'b0};
                            r_obyte  <= {r_obyte[6:0], 1'b0};
                        end
                    end
                    ST_DATA4: begin
                        r_io_oe <= 4'b1111;
                        if (r_ocnt == 3'd0) begin
                            r_io_out <= w_src[7:4];
                            r_obyte  <= {w_src[3:0], 4'b0000};
                            r_ocnt   <= 3'd1;
                            r_faddr  <= r_faddr + MEM_AW'(1);
                        end else begin
                            r_io_out <= r_obyte[7:4];
                            r_ocnt   <= 3'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign io_out  = r_io_out;
    assign io_oe   = r_io_oe;
    assign cmd_err = r_cmd_err;
    assign busy    = ~w_cs_n & (r_state != ST_IDLE);

endmodule

// File: tb/tb_qspi_flash_responder.sv
module tb_qspi_flash_responder;

    localparam int          MEM_AW = 10;
    localparam int          DEPTH  = 1 << MEM_AW;
    localparam int          DUMMY  = 8;
    localparam int          HALF   = 8;
    localparam logic [23:0] JID    = 24'hEF4018;
    localparam logic [7:0]  SVAL   = 8'h00;

    logic              mclk = 1'b0;
    logic              RESETn = 1'b0;
    logic              sck = 1'b0;
    logic              cs_n = 1'b1;
    logic [3:0]        io_in = 4'h0;
    logic [3:0]        io_out;
    logic [3:0]        io_oe;
    logic              mem_we = 1'b0;
    logic [MEM_AW-1:0] mem_addr = '0;
    logic [7:0]        mem_wdata = 8'h00;
    logic              busy;
    logic              cmd_err;

    qspi_flash_responder #(
        .MEM_AW(MEM_AW), .DUMMY_CYC(DUMMY), .JEDEC_ID(JID), .STATUS_VAL(SVAL)
    ) dut (
        .mclk(mclk), .RESETn(RESETn), .sck(sck), .cs_n(cs_n), .io_in(io_in),
        .io_out(io_out), .io_oe(io_oe), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [7:0] b;
        logic [3:0] oe;
    } exp_t;

    int         total = 0;
    int         bad = 0;
    exp_t       exp_q[$];
    logic [7:0] mdl_mem [DEPTH];
    bit         data_phase = 1'b0;
    bit         mon_quiet = 1'b0;
    int         err_seen = 0;
    int         err_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge mclk) if (cmd_err === 1'b1) err_seen++;

    // Monitor: samples the flash outputs on each master SCK rise.
    int         mon_n = 0;
    logic [7:0] mon_acc = 8'h00;
    exp_t       mon_e;
    always @(posedge sck or posedge cs_n) begin
        if (cs_n) begin
            mon_n = 0;
        end else if (!mon_quiet) begin
            if (!data_phase) begin
                check("idle_oe", {28'd0, io_oe}, 32'd0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_drive", {28'd0, io_oe}, 32'd0);
            end else begin
                check("data_oe", {28'd0, io_oe}, {28'd0, exp_q[0].oe});
                if (exp_q[0].oe == 4'b1111) begin
                    mon_acc = {mon_acc[3:0], io_out};
                    mon_n += 4;
                end else begin
                    mon_acc = {mon_acc[6:0], io_out[1]};
                    mon_n += 1;
                end
                if (mon_n >= 8) begin
                    mon_e = exp_q.pop_front();
                    check("data_byte", {24'd0, mon_acc}, {24'd0, mon_e.b});
                    mon_n = 0;
                end
            end
        end
    end

    task automatic wait_mclk(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic send_bit(input logic b);
        io_in[3:1] = 3'($urandom_range(0, 7));
        io_in[0]   = b;
        wait_mclk(HALF);
        sck = 1'b1;
        wait_mclk(HALF);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic preload(input int a, input logic [7:0] d);
        @(negedge mclk);
        mem_we = 1'b1; mem_addr = a[MEM_AW-1:0]; mem_wdata = d;
        @(negedge mclk);
        mem_we = 1'b0;
        mdl_mem[a] = d;
    endtask

    task automatic preload_all();
        logic [7:0] d;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge mclk);
            d = 8'($urandom);
            mem_we = 1'b1; mem_addr = a[MEM_AW-1:0]; mem_wdata = d;
            mdl_mem[a] = d;
        end
        @(negedge mclk);
        mem_we = 1'b0;
    endtask

    // Expected response: what a NOR flash returns for this command.
    task automatic push_expected(input logic [7:0] op, input logic [23:0] addr, input int nbytes);
        exp_t       e;
        logic [23:0] jid;
        jid = JID;
        for (int i = 0; i < nbytes; i++) begin
            case (op)
                8'h03:   begin e.b = mdl_mem[(int'(addr) + i) % DEPTH]; e.oe = 4'b0010; end
                8'h6B:   begin e.b = mdl_mem[(int'(addr) + i) % DEPTH]; e.oe = 4'b1111; end
                8'h9F:   begin e.b = (i < 3) ? jid[23 - 8*i -: 8] : 8'h00; e.oe = 4'b0010; end
                default: begin e.b = SVAL; e.oe = 4'b0010; end
            endcase
            exp_q.push_back(e);
        end
    endtask

    // abort_at >= 0: raise cs_n after that many address bits.
    task automatic xact(input logic [7:0] op, input logic [23:0] addr, input int nbytes, input int abort_at);
        int nab;
        int nclk;
        @(negedge mclk);
        cs_n = 1'b0;
        wait_mclk(HALF);
        send_bits({24'd0, op}, 8);
        check("busy_in_xact", {31'd0, busy}, 32'd1);
        if (op == 8'h03 || op == 8'h6B) begin
            nab = (abort_at >= 0) ? abort_at : 24;
            for (int i = 0; i < nab; i++) send_bit(addr[23 - i]);
            if (abort_at < 0) begin
                if (op == 8'h6B) for (int i = 0; i < DUMMY; i++) send_bit(1'b0);
                push_expected(op, addr, nbytes);
                data_phase = 1'b1;
                nclk = (op == 8'h6B) ? nbytes * 2 : nbytes * 8;
                for (int i = 0; i < nclk; i++) send_bit(1'b0);
            end
        end else if (op == 8'h9F || op == 8'h05) begin
            push_expected(op, addr, nbytes);
            data_phase = 1'b1;
            for (int i = 0; i < nbytes * 8; i++) send_bit(1'b0);
        end else begin
            err_exp++;
            for (int i = 0; i < 16; i++) send_bit(1'($urandom));
        end
        data_phase = 1'b0;
        wait_mclk(HALF);
        cs_n = 1'b1;
        wait_mclk(6);
        check("oe_after_cs", {28'd0, io_oe}, 32'd0);
        check("busy_after_cs", {31'd0, busy}, 32'd0);
        check("cmd_err_count", err_seen, err_exp);
        check("leftover_bytes", exp_q.size(), 32'd0);
        exp_q.delete();
        // SCK activity while deselected must be ignored.
        repeat ($urandom_range(0, 3)) begin
            io_in = 4'($urandom);
            wait_mclk(4); sck = 1'b1; wait_mclk(4); sck = 1'b0;
        end
        wait_mclk(6);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        logic [7:0]  op;
        logic [23:0] a;
        int          sel;
        int          nb;
        int          ab;

        RESETn = 1'b0;
        wait_mclk(4);
        check("rst_io_oe", {28'd0, io_oe}, 32'd0);
        check("rst_io_out", {28'd0, io_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        RESETn = 1'b1;
        wait_mclk(4);

        preload_all();
        preload(0, 8'h11); preload(1, 8'h22); preload(2, 8'h33); preload(3, 8'h44);

        xact(8'h03, 24'h000000, 4, -1);
        xact(8'h6B, 24'h000002, 2, -1);
        xact(8'h03, 24'h0003FF, 2, -1);
        xact(8'h03, 24'h7A83FE, 3, -1);
        xact(8'h9F, 24'h000000, 4, -1);
        xact(8'h05, 24'h000000, 2, -1);
        xact(8'hAB, 24'h000000, 0, -1);
        xact(8'h03, 24'h000010, 0, 10);
        xact(8'h03, 24'h000000, 4, -1);

        for (int t = 0; t < 25; t++) begin
            sel = $urandom_range(0, 9);
            a   = 24'($urandom);
            nb  = $urandom_range(1, 4);
            ab  = -1;
            if ($urandom_range(0, 3) == 0) preload($urandom_range(0, DEPTH - 1), 8'($urandom));
            if (sel <= 3)      op = 8'h03;
            else if (sel <= 6) op = 8'h6B;
            else if (sel == 7) op = 8'h9F;
            else if (sel == 8) op = 8'h05;
            else begin
                op = 8'($urandom);
                while (op == 8'h03 || op == 8'h6B || op == 8'h9F || op == 8'h05) op = 8'($urandom);
            end
            if ((op == 8'h03 || op == 8'h6B) && $urandom_range(0, 5) == 0) ab = $urandom_range(0, 23);
            xact(op, a, nb, ab);
        end

        // Reset in the middle of a quad read, with cs_n held low through release.
        mon_quiet = 1'b1;
        @(negedge mclk);
        cs_n = 1'b0;
        wait_mclk(HALF);
        send_bits(32'h6B, 8);
        send_bits(32'h000001, 24);
        for (int i = 0; i < DUMMY; i++) send_bit(1'b0);
        wait_mclk(5);
        check("qread_drive_pre_reset", {28'd0, io_oe}, 32'hF);
        RESETn = 1'b0;
        #1;
        check("reset_oe_async", {28'd0, io_oe}, 32'd0);
        check("reset_out_async", {28'd0, io_out}, 32'd0);
        wait_mclk(3);
        RESETn = 1'b1;
        wait_mclk(4);
        mon_quiet = 1'b0;
        send_bits(32'h0000_0300, 16);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        check("post_reset_oe", {28'd0, io_oe}, 32'd0);
        wait_mclk(HALF);
        cs_n = 1'b1;
        wait_mclk(8);

        preload(5, 8'hA5); preload(6, 8'h5A);
        xact(8'h03, 24'h000005, 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
